inst_aligner: RTL and testbench

INST_ALIGNER -- requirements
Module: inst_aligner

---
 rtl/rv_inst_pkg.sv | 26 ++
 rtl/inst_aligner_buf.sv | 68 ++++++
 rtl/inst_aligner.sv | 87 ++++++++
 tb/tb_inst_aligner.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_inst_pkg.sv
// ============================================================================
// Module  : rv_inst_pkg
// Brief   : Shared RISC-V instruction types and RVC encoding constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_inst_pkg;

    typedef logic [15:0] halfword_t;

    // RVC quadrant encodings in bits [1:0]; NONC marks a 32-bit instruction
    localparam logic [1:0] C0   = 2'b00;
    localparam logic [1:0] C1   = 2'b01;
    localparam logic [1:0] C2   = 2'b10;
    localparam logic [1:0] NONC = 2'b11;

    localparam halfword_t ILLEGAL_C = 16'h0000;

    function automatic logic is_compressed(input halfword_t hw);
        return hw[1:0] != NONC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_aligner_buf.sv
// ============================================================================
// Module  : inst_aligner_buf
// Brief   : Three-halfword FIFO-style buffer; consume from the head, append at tail.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_aligner_buf
    import rv_inst_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clear,
    input  logic [1:0] cons_n,
    input  logic [1:0] app_n,
    input  halfword_t app_lo,
    input  halfword_t app_hi,
    output halfword_t head0,
    output halfword_t head1,
    output logic [1:0] cnt
);

    halfword_t  hw_q [3];
    halfword_t  hw_d [3];
    halfword_t  sh   [3];
    halfword_t  app_first;
    logic [1:0] cnt_q;
    logic [1:0] keep;

    always_comb begin
        keep      = cnt_q - cons_n;
        app_first = (app_n == 2'd1) ? app_hi : app_lo;
        for (int i = 0; i < 3; i++) sh[i] = hw_q[i];
        case (cons_n)
            2'd1: begin
                sh[0] = hw_q[1];
                sh[1] = hw_q[2];
            end
            2'd2: sh[0] = hw_q[2];
            default: ;
        endcase
        // Appended halfwords land directly after the surviving entries
        for (int i = 0; i < 3; i++) begin
            hw_d[i] = sh[i];
            if ((3'(i) >= {1'b0, keep}) && ((3'(i) - {1'b0, keep}) < {1'b0, app_n}))
                hw_d[i] = (3'(i) == {1'b0, keep}) ? app_first : app_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            for (int i = 0; i < 3; i++) hw_q[i] <= '0;
        end else if (clear) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= keep + app_n;
            for (int i = 0; i < 3; i++) hw_q[i] <= hw_d[i];
        end
    end

    assign head0 = hw_q[0];
    assign head1 = hw_q[1];
    assign cnt   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/inst_aligner.sv
// ============================================================================
// Module  : inst_aligner
// Brief   : Splits word fetches into aligned 16/32-bit RISC-V instructions.
//           Optional define ALIGNER_ILLEGAL_CHK_EN flags the all-zero RVC word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_aligner
    import rv_inst_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fw_valid,
    input  logic [31:0] fw_data,
    output logic        fw_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_is_c,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    halfword_t   head0;
    halfword_t   head1;
    logic [1:0]  cnt;
    logic [31:0] pc_q;
    logic        skip_q;
    logic        head_c;
    logic        fire;
    logic        accept;
    logic [1:0]  cons_n;
    logic [1:0]  app_n;

    assign head_c    = is_compressed(head0);
    assign out_valid = ((cnt != 2'd0) && head_c) || (cnt >= 2'd2);
    assign fire      = out_valid && out_ready;
    assign cons_n    = fire ? (head_c ? 2'd1 : 2'd2) : 2'd0;
    // rst_n gates acceptance so nothing is taken while reset is held
    assign fw_ready  = rst_n && !flush && ((cnt - cons_n) <= 2'd1);
    assign accept    = fw_valid && fw_ready;
    assign app_n     = accept ? (skip_q ? 2'd1 : 2'd2) : 2'd0;

    inst_aligner_buf u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (flush),
        .cons_n (cons_n),
        .app_n  (app_n),
        .app_lo (fw_data[15:0]),
        .app_hi (fw_data[31:16]),
        .head0  (head0),
        .head1  (head1),
        .cnt    (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            skip_q <= RESET_PC[1];
        end else if (flush) begin
            pc_q   <= flush_pc;
            skip_q <= flush_pc[1];
        end else begin
            if (fire)   pc_q   <= pc_q + (head_c ? 32'd2 : 32'd4);
            if (accept) skip_q <= 1'b0;
        end
    end

    assign out_inst = out_valid ? (head_c ? {16'h0000, head0} : {head1, head0}) : 32'h0;
    assign out_is_c = out_valid && head_c;
    assign out_pc   = pc_q;

`ifdef ALIGNER_ILLEGAL_CHK_EN
    assign out_illegal = out_valid && head_c && (head0 == ILLEGAL_C);
`else
    assign out_illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_aligner.sv
// ============================================================================
// Module  : tb_inst_aligner
// Brief   : Scoreboard bench for inst_aligner (expected stream built from accepted words).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef ALIGNER_ILLEGAL_CHK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        fw_valid;
    logic [31:0] fw_data;
    logic        fw_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_is_c;
    logic [31:0] out_pc;
    logic        out_illegal;

    inst_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fw_valid    (fw_valid),
        .fw_data     (fw_data),
        .fw_ready    (fw_ready),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_is_c    (out_is_c),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_c;
        logic        ill;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] hq[$];
    logic [31:0] mpc;
    bit          mskip;
    exp_t        m_e;
    exp_t        got;
    int          checks = 0;
    int          errors = 0;

    always @(negedge rst_n) begin
        hq.delete(); expq.delete(); mpc = RESET_PC; mskip = RESET_PC[1];
    end

    // Reference model and output scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            hq.delete(); expq.delete(); mpc = RESET_PC; mskip = RESET_PC[1];
        end else begin
            if (out_valid && out_ready && !flush) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got inst=%h pc=%h, required no output", out_inst, out_pc);
                end else begin
                    got = expq.pop_front();
                    if ({out_inst, out_pc, out_is_c, out_illegal} !== {got.inst, got.pc, got.is_c, got.ill}) begin
                        errors++;
                        $display("FAIL out_stream: got inst=%h pc=%h c=%b ill=%b, required inst=%h pc=%h c=%b ill=%b",
                                 out_inst, out_pc, out_is_c, out_illegal, got.inst, got.pc, got.is_c, got.ill);
                    end
                end
            end
            if (flush) begin
                hq.delete(); expq.delete(); mpc = flush_pc; mskip = flush_pc[1];
            end else if (fw_valid && fw_ready) begin
                if (!mskip) hq.push_back(fw_data[15:0]);
                hq.push_back(fw_data[31:16]);
                mskip = 1'b0;
                while (hq.size() > 0) begin
                    if (hq[0][1:0] != 2'b11) begin
                        m_e.inst = {16'h0000, hq[0]}; m_e.pc = mpc; m_e.is_c = 1'b1;
                        m_e.ill  = ILL_EN && (hq[0] == 16'h0000);
                        expq.push_back(m_e); void'(hq.pop_front()); mpc = mpc + 32'd2;
                    end else if (hq.size() >= 2) begin
                        m_e.inst = {hq[1], hq[0]}; m_e.pc = mpc; m_e.is_c = 1'b0; m_e.ill = 1'b0;
                        expq.push_back(m_e); void'(hq.pop_front()); void'(hq.pop_front());
                        mpc = mpc + 32'd4;
                    end else break;
                end
            end
        end
    end

    task automatic idle_fetch();
        fw_valid = 1'b0;
        fw_data  = $urandom;
    endtask

    task automatic send_word(input logic [31:0] w, output bit ok);
        fw_valid = 1'b1; fw_data = w; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fw_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush = 1'b1; flush_pc = pc;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (expq.size() == 0 && !out_valid) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; fw_valid = 1'b0; fw_data = $urandom; out_ready = 1'b1;
        flush = 1'b0; flush_pc = 32'h0;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        checks++; if (fw_ready !== 1'b0) begin errors++; $display("FAIL rst_fw_ready: got %b, required 0", fw_ready); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst: got %h, required 0", out_inst); end
        checks++; if ({out_is_c, out_illegal} !== 2'b00) begin errors++; $display("FAIL rst_c_ill: got %b, required 00", {out_is_c, out_illegal}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (fw_ready !== 1'b1) begin errors++; $display("FAIL rst_resume_fw_ready: got %b, required 1", fw_ready); end
        checks++; if (out_pc !== RESET_PC) begin errors++; $display("FAIL rst_pc: got %h, required %h", out_pc, RESET_PC); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok0, ok1, okd;
        out_ready = 1'b1;
        send_word(32'h00A0_0093, ok0);
        send_word(32'h0020_8133, ok1);
        idle_fetch();
        @(negedge clk);
        checks++;
        if (!(ok0 && ok1 && out_valid === 1'b1 && out_pc === 32'h4 && out_inst === 32'h0020_8133)) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b pc=%h inst=%h, required valid=1 pc=00000004 inst=00208133", out_valid, out_pc, out_inst);
        end
        @(posedge clk); #1;
        wait_drain(okd);
        checks++; if (!okd) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", expq.size()); end
    endtask

    task automatic test_compressed();
        bit ok, okd;
        do_flush(32'h0);
        out_ready = 1'b1;
        send_word(32'h4505_0505, ok);
        idle_fetch();
        @(negedge clk);
        checks++;
        if (!(ok && out_valid === 1'b1 && out_is_c === 1'b1 && out_inst === 32'h0505)) begin
            errors++;
            $display("FAIL c_first: got valid=%b c=%b inst=%h, required valid=1 c=1 inst=00000505", out_valid, out_is_c, out_inst);
        end
        @(posedge clk); #1;
        wait_drain(okd);
        checks++; if (!okd) begin errors++; $display("FAIL c_drain: got %0d pending, required 0", expq.size()); end
    endtask

    task automatic test_straddle();
        bit ok0, ok1, okd;
        do_flush(32'h0);
        out_ready = 1'b1;
        send_word(32'h0093_0505, ok0);
        send_word(32'h1111_00A0, ok1);
        idle_fetch();
        wait_drain(okd);
        checks++;
        if (!(ok0 && ok1 && okd)) begin
            errors++;
            $display("FAIL straddle: got acc=%b%b pending=%0d, required acc=11 pending=0", ok0, ok1, expq.size());
        end
    endtask

    task automatic test_flush();
        bit ok0, ok1, okd;
        out_ready = 1'b0;
        send_word(32'h0505_0505, ok0);
        idle_fetch();
        do_flush(32'h0000_0102);
        out_ready = 1'b1;
        send_word(32'h4585_DEAD, ok1);
        idle_fetch();
        @(negedge clk);
        checks++;
        if (!(ok0 && ok1 && out_valid === 1'b1 && out_inst === 32'h4585 && out_pc === 32'h102)) begin
            errors++;
            $display("FAIL flush_first: got valid=%b inst=%h pc=%h, required valid=1 inst=00004585 pc=00000102", out_valid, out_inst, out_pc);
        end
        @(posedge clk); #1;
        wait_drain(okd);
        checks++; if (!okd) begin errors++; $display("FAIL flush_drain: got %0d pending, required 0", expq.size()); end
    endtask

    task automatic test_stall();
        bit ok0, ok1, okd;
        do_flush(32'h0);
        out_ready = 1'b1;
        send_word(32'h0093_0505, ok0);
        send_word(32'h1111_00A0, ok1);
        out_ready = 1'b0;
        fw_valid = 1'b1; fw_data = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (!(ok0 && ok1 && fw_ready === 1'b0 && out_valid === 1'b1 && out_inst === 32'h00A0_0093
                  && out_pc === 32'h2 && out_is_c === 1'b0)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got rdy=%b valid=%b inst=%h pc=%h, required rdy=0 valid=1 inst=00a00093 pc=00000002",
                         i, fw_ready, out_valid, out_inst, out_pc);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fw_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b rdy=%b, required 0 0", out_valid, fw_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        idle_fetch();
        out_ready = 1'b1;
        rst_n = 1'b1;
        wait_drain(okd);
        checks++; if (!okd) begin errors++; $display("FAIL stall_drain: got %0d pending, required 0", expq.size()); end
    endtask

    task automatic test_illegal();
        bit ok, okd;
        do_flush(32'h0);
        out_ready = 1'b1;
        send_word(32'h0000_0000, ok);
        idle_fetch();
        @(negedge clk);
        checks++;
        if (!(ok && out_valid === 1'b1 && out_is_c === 1'b1 && out_illegal === ILL_EN)) begin
            errors++;
            $display("FAIL illegal: got valid=%b c=%b ill=%b, required valid=1 c=1 ill=%b", out_valid, out_is_c, out_illegal, ILL_EN);
        end
        @(posedge clk); #1;
        wait_drain(okd);
        checks++; if (!okd) begin errors++; $display("FAIL illegal_drain: got %0d pending, required 0", expq.size()); end
    endtask

    task automatic test_wrap();
        bit ok0, ok1, okd;
        do_flush(32'hFFFF_FFFC);
        out_ready = 1'b1;
        send_word(32'h0505_0505, ok0);
        send_word(32'h0505_0505, ok1);
        idle_fetch();
        wait_drain(okd);
        checks++;
        if (!(ok0 && ok1 && okd && out_pc === 32'h4)) begin
            errors++;
            $display("FAIL wrap: got acc=%b%b pending=%0d pc=%h, required acc=11 pending=0 pc=00000004", ok0, ok1, expq.size(), out_pc);
        end
    endtask

    task automatic test_random();
        bit okd;
        logic [31:0] r;
        do_flush(32'h0000_0040);
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            fw_valid  = 1'($urandom_range(0, 1));
            fw_data   = $urandom;
            r         = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            flush_pc  = r & 32'hFFFF_FFFE;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        idle_fetch();
        out_ready = 1'b1;
        wait_drain(okd);
        checks++; if (!okd) begin errors++; $display("FAIL random_drain: got %0d pending, required 0", expq.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_compressed();
        test_straddle();
        test_flush();
        test_stall();
        test_illegal();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
